// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline. Tracks rd/we/load status of EX, MEM and WB
// and derives stall, flush and operand-forwarding selects for the ID-stage instruction.
module hazard_ctrl #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_we,
  input  logic [1:0]       id_wd_sel,
  input  logic             ex_redirect,
  input  logic             hold,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } trk_t;

  trk_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic use_ex, use_mem, use_wb, data_haz, stall_evt, flush_evt;

  // x0 never matches because the rd!=0 term rejects it.
  function automatic logic hit(input trk_t e, input logic [4:0] rs);
    return e.v & e.we & (e.rd != 5'd0) & (e.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input trk_t e, input trk_t m, input trk_t w,
                                         input logic [4:0] rs);
    if (hit(e, rs))      return 2'd1;
    else if (hit(m, rs)) return 2'd2;
    else if (hit(w, rs)) return 2'd3;
    else                 return 2'd0;
  endfunction

  always_comb begin
    use_ex  = id_valid & ((id_re1 & hit(ex_q, id_rs1))  | (id_re2 & hit(ex_q, id_rs2)));
    use_mem = id_valid & ((id_re1 & hit(mem_q, id_rs1)) | (id_re2 & hit(mem_q, id_rs2)));
    use_wb  = id_valid & ((id_re1 & hit(wb_q, id_rs1))  | (id_re2 & hit(wb_q, id_rs2)));
    if (FWD_EN) data_haz = use_ex & ex_q.ld;
    else        data_haz = use_ex | use_mem | use_wb;

    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = hold;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    if (!rst_n) begin
      pipe_hold = hold;
    end else if (hold) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (ex_redirect) begin
      // The ID instruction is wrong-path, so a pending data stall is irrelevant.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (data_haz) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      stall_evt  = 1'b1;
    end

    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (FWD_EN) begin
      fwd_a_sel = fwd_sel(ex_q, mem_q, wb_q, id_rs1);
      fwd_b_sel = fwd_sel(ex_q, mem_q, wb_q, id_rs2);
    end
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_evt);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_evt);
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '{v: id_valid & ~idex_flush, rd: id_rd, we: id_rf_we, ld: (id_wd_sel == 2'd3)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: one forwarding instance (32-bit counters) and one
// non-forwarding instance (4-bit counters, so wrap-around is reachable quickly).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic idValid, idRe1, idRe2, idRfWe, exRedirect, hold;
  logic [4:0] idRs1, idRs2, idRd;
  logic [1:0] idWdSel;

  logic pcStall1, ifidStall1, ifidFlush1, idexFlush1, pipeHold1;
  logic [1:0] fwdA1, fwdB1;
  logic [31:0] stallCnt1, flushCnt1;

  logic pcStall0, ifidStall0, ifidFlush0, idexFlush0, pipeHold0;
  logic [1:0] fwdA0, fwdB0;
  logic [3:0] stallCnt0, flushCnt0;

  int nCompared = 0;
  int nMismatch = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) dutFwd (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_re1(idRe1), .id_re2(idRe2), .id_rd(idRd), .id_rf_we(idRfWe), .id_wd_sel(idWdSel),
    .ex_redirect(exRedirect), .hold(hold), .pc_stall(pcStall1), .ifid_stall(ifidStall1),
    .ifid_flush(ifidFlush1), .idex_flush(idexFlush1), .pipe_hold(pipeHold1),
    .fwd_a_sel(fwdA1), .fwd_b_sel(fwdB1), .stall_cnt(stallCnt1), .flush_cnt(flushCnt1)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(4)) dutNoFwd (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_re1(idRe1), .id_re2(idRe2), .id_rd(idRd), .id_rf_we(idRfWe), .id_wd_sel(idWdSel),
    .ex_redirect(exRedirect), .hold(hold), .pc_stall(pcStall0), .ifid_stall(ifidStall0),
    .ifid_flush(ifidFlush0), .idex_flush(idexFlush0), .pipe_hold(pipeHold0),
    .fwd_a_sel(fwdA0), .fwd_b_sel(fwdB0), .stall_cnt(stallCnt0), .flush_cnt(flushCnt0)
  );

  // One vector: ID-stage inputs plus expected outputs of the selected instance.
  // ctl packs {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_hold}.
  typedef struct {
    string      name;
    logic       use0;
    logic       valid;
    logic [4:0] rs1, rs2;
    logic       re1, re2;
    logic [4:0] rd;
    logic       we;
    logic [1:0] wdSel;
    logic       redir, hold;
    logic [4:0] ctl;
    logic [1:0] fa, fb;
    logic [31:0] scnt, fcnt;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[$];

  function automatic vec_t mk(string name, logic use0, logic valid, logic [4:0] rs1, logic [4:0] rs2,
                              logic re1, logic re2, logic [4:0] rd, logic we, logic ld,
                              logic redir, logic hld, logic [4:0] ctl, logic [1:0] fa,
                              logic [1:0] fb, int sc, int fc);
    vec_t v;
    v.name = name;   v.use0 = use0;   v.valid = valid;
    v.rs1 = rs1;     v.rs2 = rs2;     v.re1 = re1;     v.re2 = re2;
    v.rd = rd;       v.we = we;       v.wdSel = ld ? 2'd3 : 2'd0;
    v.redir = redir; v.hold = hld;
    v.ctl = ctl;     v.fa = fa;       v.fb = fb;
    v.scnt = 32'(sc); v.fcnt = 32'(fc);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the ID-stage inputs and queue the outputs they must produce.
  task automatic applyStimulus(input vec_t v);
    idValid = v.valid; idRs1 = v.rs1; idRs2 = v.rs2; idRe1 = v.re1; idRe2 = v.re2;
    idRd = v.rd; idRfWe = v.we; idWdSel = v.wdSel; exRedirect = v.redir; hold = v.hold;
    sbq.push_back(v);
  endtask

  // Pop the oldest expectation and compare it against the chosen instance.
  task automatic checkOutput();
    vec_t e;
    if (sbq.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    if (e.use0) begin
      cmp({e.name, ".ctl"}, 32'({pcStall0, ifidStall0, ifidFlush0, idexFlush0, pipeHold0}), 32'(e.ctl));
      cmp({e.name, ".fwd_a"}, 32'(fwdA0), 32'(e.fa));
      cmp({e.name, ".fwd_b"}, 32'(fwdB0), 32'(e.fb));
      cmp({e.name, ".stall_cnt"}, 32'(stallCnt0), e.scnt);
      cmp({e.name, ".flush_cnt"}, 32'(flushCnt0), e.fcnt);
    end else begin
      cmp({e.name, ".ctl"}, 32'({pcStall1, ifidStall1, ifidFlush1, idexFlush1, pipeHold1}), 32'(e.ctl));
      cmp({e.name, ".fwd_a"}, 32'(fwdA1), 32'(e.fa));
      cmp({e.name, ".fwd_b"}, 32'(fwdB1), 32'(e.fb));
      cmp({e.name, ".stall_cnt"}, stallCnt1, e.scnt);
      cmp({e.name, ".flush_cnt"}, flushCnt1, e.fcnt);
    end
  endtask

  // Called 1 time unit after a rising edge; leaves the bench at the same phase of the next cycle.
  task automatic stepVec(input vec_t v);
    applyStimulus(v);
    #3;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idValid = 0; idRs1 = 0; idRs2 = 0; idRe1 = 0; idRe2 = 0;
    idRd = 0; idRfWe = 0; idWdSel = 0; exRedirect = 0; hold = 0;
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    idValid = 0; idRs1 = 0; idRs2 = 0; idRe1 = 0; idRe2 = 0;
    idRd = 0; idRfWe = 0; idWdSel = 0; exRedirect = 0; hold = 0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding instance walk-through; tracker contents carry from one row to the next.
    tbl.push_back(mk("reset_idle",       0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    tbl.push_back(mk("lw_x5",            0, 1,  1, 0, 1, 0,  5, 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0));
    tbl.push_back(mk("loaduse_stall",    0, 1,  5, 1, 1, 1,  6, 1, 0, 0, 0, 5'b11010, 1, 0, 0, 0));
    tbl.push_back(mk("loaduse_fwd_mem",  0, 1,  5, 1, 1, 1,  6, 1, 0, 0, 0, 5'b00000, 2, 0, 1, 0));
    tbl.push_back(mk("addi_x5_x0",       0, 1,  0, 0, 1, 0,  5, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0));
    tbl.push_back(mk("addi_x5_x5",       0, 1,  5, 0, 1, 0,  5, 1, 0, 0, 0, 5'b00000, 1, 0, 1, 0));
    tbl.push_back(mk("ex_beats_mem",     0, 1,  5, 6, 1, 1,  7, 1, 0, 0, 0, 5'b00000, 1, 3, 1, 0));
    tbl.push_back(mk("write_x0",         0, 1,  0, 0, 1, 0,  0, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0));
    tbl.push_back(mk("read_x0",          0, 1,  0, 0, 1, 1,  8, 1, 0, 0, 0, 5'b00000, 0, 0, 1, 0));
    tbl.push_back(mk("lw_x9",            0, 1,  0, 0, 1, 0,  9, 1, 1, 0, 0, 5'b00000, 0, 0, 1, 0));
    tbl.push_back(mk("redirect_wins",    0, 1,  9, 0, 1, 1, 10, 1, 0, 1, 0, 5'b00110, 1, 0, 1, 0));
    tbl.push_back(mk("after_redirect",   0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 1));
    tbl.push_back(mk("lw_x11",           0, 1,  0, 0, 1, 0, 11, 1, 1, 0, 0, 5'b00000, 0, 0, 1, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("hold_loaduse",   0, 1, 11, 0, 1, 0, 12, 1, 0, 0, 1, 5'b11001, 1, 0, 1, 1));
    tbl.push_back(mk("stall_after_hold", 0, 1, 11, 0, 1, 0, 12, 1, 0, 0, 0, 5'b11010, 1, 0, 1, 1));
    tbl.push_back(mk("fwd_after_hold",   0, 1, 11, 0, 1, 0, 12, 1, 0, 0, 0, 5'b00000, 2, 0, 2, 1));
    tbl.push_back(mk("redirect_in_hold", 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 1, 5'b11001, 0, 0, 2, 1));
    tbl.push_back(mk("redirect_release", 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 0, 5'b00110, 0, 0, 2, 1));
    tbl.push_back(mk("idle_end",         0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 5'b00000, 0, 0, 2, 2));
    foreach (tbl[i]) stepVec(tbl[i]);

    // Non-forwarding instance: the producer blocks the consumer for exactly three cycles.
    doReset();
    stepVec(mk("nf_addi_x5",   1, 1, 0, 0, 1, 0, 5, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      stepVec(mk("nf_stall",   1, 1, 5, 0, 1, 1, 6, 1, 0, 0, 0, 5'b11010, 0, 0, i, 0));
    stepVec(mk("nf_release",   1, 1, 5, 0, 1, 1, 6, 1, 0, 0, 0, 5'b00000, 0, 0, 3, 0));

    // Sixteen redirects wrap the 4-bit flush counter back to zero.
    for (int i = 0; i < 16; i++)
      stepVec(mk("nf_redirect", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00110, 0, 0, 3, i));
    stepVec(mk("nf_wrapped",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 3, 0));
    stepVec(mk("fw_no_wrap",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 16));

    // Asynchronous reset in the middle of a load-use stall.
    doReset();
    stepVec(mk("rs_lw_x5",     0, 1, 0, 0, 1, 0, 5, 1, 1, 0, 0, 5'b00000, 0, 0, 0, 0));
    stepVec(mk("rs_stall1",    0, 1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 5'b11010, 1, 0, 0, 0));
    stepVec(mk("rs_lw_x7",     0, 1, 0, 0, 1, 0, 7, 1, 1, 0, 0, 5'b00000, 0, 0, 1, 0));
    v = mk("rs_stall2",        0, 1, 7, 0, 1, 0, 8, 1, 0, 0, 0, 5'b11010, 1, 0, 1, 0);
    applyStimulus(v);
    #2;
    checkOutput();
    rst_n = 1'b0;
    v.name = "reset_mid_stall"; v.ctl = 5'b00000; v.fa = 0; v.scnt = 0;
    sbq.push_back(v);
    #1;
    checkOutput();
    hold = 1'b1;
    v.name = "reset_with_hold"; v.ctl = 5'b00001; v.hold = 1'b1;
    sbq.push_back(v);
    #1;
    checkOutput();
    hold = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cmp("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
